reg_bank: RTL and testbench
===========================

// Module: reg_bank
// PURPOSE
//  Architectural register bank of the CPU register file. Sits directly downstream of the
//  4->16 write-address decoder: consumes its one-hot select to write one register per
//  cycle, serves two combinational read ports with write-forwarding, and keeps a
//  per-register pending scoreboard so issue logic can stall on in-flight results.
// PARAMETERS
//  DATA_W   32   width of each register and of all data ports
//  NREG     16   number of registers; equals one-hot select width
//  ADDR_W   4    read/reserve address width, $clog2(NREG)
// PORTS
//  clk          in   1       single clock, all state updates on rising edge
//  rst_n        in   1       reset, asynchronous assert, active-low
//  wr_en        in   1       writeback strobe
//  wr_onehot    in   NREG    one-hot destination select from the address decoder
//  wr_data      in   DATA_W  writeback data
//  rd_addr_a    in   ADDR_W  read port A address
//  rd_addr_b    in   ADDR_W  read port B address
//  rd_data_a    out  DATA_W  read port A data (combinational)
//  rd_data_b    out  DATA_W  read port B data (combinational)
//  rsv_en       in   1       issue-time reservation strobe
//  rsv_addr     in   ADDR_W  destination register being reserved
//  busy_a       out  1       operand A register awaiting a result
//  busy_b       out  1       operand B register awaiting a result
//  pending      out  NREG    scoreboard vector, bit i = register i pending
//  onehot_err   out  1       registered pulse: illegal wr_onehot seen with wr_en
// BEHAVIOUR
//  - Reset (rst_n=0, any time, async): all registers 0, pending 0, onehot_err 0.
//    Reset mid-write discards the write; first legal write is the first edge after release.
//  - Legal write: wr_en=1 and wr_onehot has exactly one bit set (bit i). At the edge:
//    reg[i] <= wr_data; pending[i] <= 0. One-cycle write latency.
//  - Illegal write: wr_en=1 and wr_onehot zero or multi-hot. No register changes, no pending
//    bit clears; onehot_err=1 for exactly the following cycle. wr_en=0 ignores wr_onehot entirely.
//  - Reads: rd_data_x = reg[rd_addr_x]; if a legal write targets rd_addr_x in the same
//    cycle, rd_data_x = wr_data (forwarding). Both ports may read the same register.
//  - Reservation: rsv_en=1 sets pending[rsv_addr] at the edge.
//  - Same-cycle reserve and legal write to the same register: write data lands, pending
//    ends SET (new producer supersedes the retiring one).
//  - busy_x = pending[rd_addr_x] AND NOT (legal write to rd_addr_x this cycle), i.e. the
//    forwarded result releases the stall combinationally.
//  - Reserve of an already-pending register: stays pending (no count, no error).
//  - No state machine beyond the register array, the pending vector and the error flop.
// STRUCTURE
//  - rf_pkg: DATA_W, NREG, ADDR_W constants; typedef reg_idx_t (logic [ADDR_W-1:0]);
//    typedef reg_word_t (logic [DATA_W-1:0]); typedef reg_sel_t (logic [NREG-1:0]).
//  - Sub-module onehot_check: input reg_sel_t, outputs valid (exactly one bit) and
//    reg_idx_t index; purely combinational, reused by forwarding and busy logic.
//  - Register array and pending vector in one always_ff with async active-low reset.
// TESTING
//  1. Reset release, read all 16 registers on both ports -> every rd_data = 0, pending = 0.
//  2. wr_en=1, wr_onehot=16'h0020, wr_data=32'hDEADBEEF, rd_addr_a=5 same cycle ->
//     rd_data_a=DEADBEEF that cycle (forward) and after the edge (stored).
//  3. wr_en=1, wr_onehot=16'h0006 (multi-hot) then 16'h0000 -> no register changes,
//     onehot_err=1 in each following cycle; wr_en=0 with 16'h0006 -> onehot_err=0.
//  4. rsv_en=1 rsv_addr=3; next cycle rd_addr_b=3 -> busy_b=1, pending=16'h0008;
//     legal write to reg 3 -> busy_b=0 same cycle, pending=0 after edge.
//  5. Same cycle rsv_en addr 7 and legal write wr_onehot=16'h0080 data 32'h1234 ->
//     reg7=0x1234, pending[7]=1 after edge.
//  6. Assert rst_n low between edges after several writes/reservations -> outputs 0 at once,
//     no write on the edge coinciding with reset.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: register-file widths and shared index/word/select types.
package rf_pkg;
    localparam int DATA_W = 32;
    localparam int NREG   = 16;
    localparam int ADDR_W = $clog2(NREG);
    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_word_t;
    typedef logic [NREG-1:0]   reg_sel_t;
endpackage

// File: rtl/onehot_check.sv
// onehot_check: flags an exactly-one-hot select and encodes its bit position.
module onehot_check
    import rf_pkg::*;
(
    input  reg_sel_t sel,
    output logic     valid,
    output reg_idx_t index
);
    assign valid = (sel != '0) && ((sel & (sel - reg_sel_t'(1))) == '0);
    always_comb begin
        index = '0;
        for (int i = 0; i < NREG; i++)
            if (sel[i]) index = reg_idx_t'(i);
    end
endmodule

// File: rtl/reg_bank.sv
// reg_bank: architectural register array with one-hot writeback, two forwarding
// read ports and a per-register pending scoreboard for issue stalls.
module reg_bank
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [NREG-1:0]   wr_onehot,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              busy_a,
    output logic              busy_b,
    output logic [NREG-1:0]   pending,
    output logic              onehot_err
);
    reg_word_t regs [NREG];
    logic      sel_valid;
    reg_idx_t  wr_idx;
    logic      legal, hit_a, hit_b;
    reg_sel_t  next_pending;

    onehot_check u_check (.sel(wr_onehot), .valid(sel_valid), .index(wr_idx));

    assign legal     = wr_en & sel_valid;
    assign hit_a     = legal && (wr_idx == rd_addr_a);
    assign hit_b     = legal && (wr_idx == rd_addr_b);
    assign rd_data_a = hit_a ? wr_data : regs[rd_addr_a];
    assign rd_data_b = hit_b ? wr_data : regs[rd_addr_b];
    assign busy_a    = pending[rd_addr_a] & ~hit_a;
    assign busy_b    = pending[rd_addr_b] & ~hit_b;
    // Reservation is applied after the retire-clear so a new producer wins.
    assign next_pending = (pending & ~(legal ? wr_onehot : '0))
                        | (rsv_en ? (reg_sel_t'(1) << rsv_addr) : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            pending    <= '0;
            onehot_err <= 1'b0;
        end else begin
            if (legal) regs[wr_idx] <= wr_data;
            pending    <= next_pending;
            onehot_err <= wr_en & ~sel_valid;
        end
    end
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: scoreboard bench for reg_bank; expected read data is queued from a
// bench-side register model and popped when the DUT output is sampled.
module tb_reg_bank;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [15:0] wr_onehot;
    logic [31:0] wr_data;
    logic [3:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    logic        busy_a, busy_b;
    logic [15:0] pending;
    logic        onehot_err;

    logic [31:0] model [16];
    logic [31:0] exp_q [$];
    logic [31:0] e;
    int checks = 0;
    int passed = 0;

    reg_bank dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_onehot(wr_onehot), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_a(busy_a), .busy_b(busy_b),
        .pending(pending), .onehot_err(onehot_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            rd_addr_b = 4'(15 - i);
            exp_q.push_back(model[i]);
            exp_q.push_back(model[15 - i]);
            #1;
            checks++; e = exp_q.pop_front();
            if (rd_data_a !== e) $display("FAIL reset_rd_a[%0d] got=%h exp=%h", i, rd_data_a, e); else passed++;
            checks++; e = exp_q.pop_front();
            if (rd_data_b !== e) $display("FAIL reset_rd_b[%0d] got=%h exp=%h", 15 - i, rd_data_b, e); else passed++;
        end
        checks++;
        if (pending !== 16'h0) $display("FAIL reset_pending got=%h exp=0000", pending); else passed++;
        checks++;
        if (onehot_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", onehot_err); else passed++;
    endtask

    task automatic test_forward();
        step();
        wr_en = 1'b1; wr_onehot = 16'h0020; wr_data = 32'hDEADBEEF;
        rd_addr_a = 4'd5; rd_addr_b = 4'd5;
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        #1;
        checks++; e = exp_q.pop_front();
        if (rd_data_a !== e) $display("FAIL fwd_a got=%h exp=%h", rd_data_a, e); else passed++;
        checks++; e = exp_q.pop_front();
        if (rd_data_b !== e) $display("FAIL fwd_b got=%h exp=%h", rd_data_b, e); else passed++;
        step();
        model[5] = 32'hDEADBEEF;
        wr_en = 1'b0; wr_data = 32'h0;
        rd_addr_b = 4'd4;
        exp_q.push_back(model[5]);
        exp_q.push_back(model[4]);
        #1;
        checks++; e = exp_q.pop_front();
        if (rd_data_a !== e) $display("FAIL stored_a got=%h exp=%h", rd_data_a, e); else passed++;
        checks++; e = exp_q.pop_front();
        if (rd_data_b !== e) $display("FAIL stored_b4 got=%h exp=%h", rd_data_b, e); else passed++;
    endtask

    task automatic test_illegal();
        logic [15:0] sels [3] = '{16'h0006, 16'h0000, 16'h0006};
        logic        ens  [3] = '{1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 3; c++) begin
            wr_en = ens[c]; wr_onehot = sels[c]; wr_data = 32'hFFFF_FFFF;
            rd_addr_a = 4'd1; rd_addr_b = 4'd0;
            exp_q.push_back(model[1]);
            exp_q.push_back(model[0]);
            #1;
            checks++; e = exp_q.pop_front();
            if (rd_data_a !== e) $display("FAIL ill_nofwd_a[%0d] got=%h exp=%h", c, rd_data_a, e); else passed++;
            checks++; e = exp_q.pop_front();
            if (rd_data_b !== e) $display("FAIL ill_nofwd_b[%0d] got=%h exp=%h", c, rd_data_b, e); else passed++;
            step();
            wr_en = 1'b0;
            checks++;
            if (onehot_err !== ens[c]) $display("FAIL ill_err[%0d] got=%b exp=%b", c, onehot_err, ens[c]); else passed++;
            for (int r = 0; r < 3; r++) begin
                rd_addr_a = 4'(r);
                exp_q.push_back(model[r]);
                #1;
                checks++; e = exp_q.pop_front();
                if (rd_data_a !== e) $display("FAIL ill_reg%0d[%0d] got=%h exp=%h", r, c, rd_data_a, e); else passed++;
            end
        end
        step();
        checks++;
        if (onehot_err !== 1'b0) $display("FAIL ill_err_idle got=%b exp=0", onehot_err); else passed++;
    endtask

    task automatic test_reserve();
        rsv_en = 1'b1; rsv_addr = 4'd3;
        step();
        rsv_en = 1'b0;
        rd_addr_b = 4'd3;
        #1;
        checks++;
        if (busy_b !== 1'b1) $display("FAIL rsv_busy_b got=%b exp=1", busy_b); else passed++;
        checks++;
        if (pending !== 16'h0008) $display("FAIL rsv_pending got=%h exp=0008", pending); else passed++;
        rsv_en = 1'b1; rsv_addr = 4'd3;
        step();
        rsv_en = 1'b0;
        checks++;
        if (pending !== 16'h0008) $display("FAIL rsv_twice got=%h exp=0008", pending); else passed++;
        wr_en = 1'b1; wr_onehot = 16'h0008; wr_data = 32'hCAFE0003;
        exp_q.push_back(32'hCAFE0003);
        #1;
        checks++;
        if (busy_b !== 1'b0) $display("FAIL rsv_release got=%b exp=0", busy_b); else passed++;
        checks++; e = exp_q.pop_front();
        if (rd_data_b !== e) $display("FAIL rsv_fwd_b got=%h exp=%h", rd_data_b, e); else passed++;
        step();
        model[3] = 32'hCAFE0003;
        wr_en = 1'b0;
        exp_q.push_back(model[3]);
        #1;
        checks++;
        if (pending !== 16'h0000) $display("FAIL rsv_cleared got=%h exp=0000", pending); else passed++;
        checks++; e = exp_q.pop_front();
        if (rd_data_b !== e) $display("FAIL rsv_stored got=%h exp=%h", rd_data_b, e); else passed++;
    endtask

    task automatic test_rsv_write();
        rsv_en = 1'b1; rsv_addr = 4'd7;
        wr_en = 1'b1; wr_onehot = 16'h0080; wr_data = 32'h0000_1234;
        step();
        model[7] = 32'h0000_1234;
        rsv_en = 1'b0; wr_en = 1'b0;
        rd_addr_a = 4'd7;
        exp_q.push_back(model[7]);
        #1;
        checks++; e = exp_q.pop_front();
        if (rd_data_a !== e) $display("FAIL rw_data got=%h exp=%h", rd_data_a, e); else passed++;
        checks++;
        if (pending !== 16'h0080) $display("FAIL rw_pending got=%h exp=0080", pending); else passed++;
        checks++;
        if (busy_a !== 1'b1) $display("FAIL rw_busy_a got=%b exp=1", busy_a); else passed++;
    endtask

    task automatic test_async_reset();
        wr_en = 1'b1; wr_onehot = 16'h0200; wr_data = 32'h0000_0099;
        rsv_en = 1'b1; rsv_addr = 4'd10;
        step();
        model[9] = 32'h0000_0099;
        rsv_en = 1'b0;
        wr_onehot = 16'h0C00;
        step();
        checks++;
        if (onehot_err !== 1'b1 || pending !== 16'h0480)
            $display("FAIL ar_pre got=%b/%h exp=1/0480", onehot_err, pending);
        else passed++;
        wr_onehot = 16'h0800; wr_data = 32'h0000_00BB;
        rd_addr_a = 4'd9; rd_addr_b = 4'd10;
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        exp_q.push_back(model[9]);
        #1;
        checks++; e = exp_q.pop_front();
        if (rd_data_a !== e) $display("FAIL ar_reg9 got=%h exp=%h", rd_data_a, e); else passed++;
        checks++;
        if (pending !== 16'h0000) $display("FAIL ar_pending got=%h exp=0000", pending); else passed++;
        checks++;
        if (onehot_err !== 1'b0) $display("FAIL ar_err got=%b exp=0", onehot_err); else passed++;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_addr_b = 4'd11;
        exp_q.push_back(model[11]);
        #1;
        checks++; e = exp_q.pop_front();
        if (rd_data_b !== e) $display("FAIL ar_nowrite got=%h exp=%h", rd_data_b, e); else passed++;
        checks++;
        if (pending !== 16'h0000) $display("FAIL ar_pending_post got=%h exp=0000", pending); else passed++;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_onehot = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; rsv_en = 1'b0; rsv_addr = '0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        test_reset();
        test_forward();
        test_illegal();
        test_reserve();
        test_rsv_write();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
